mul_seq: RTL and testbench



---
 rtl/mul_seq_pkg.sv | 13 +
 rtl/mul_seq_rca.sv | 41 ++++
 rtl/mul_seq.sv | 131 +++++++++++++
 tb/tb_mul_seq.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared ALU package: state encoding and default
// operand width for the sequential multiplier.
package mul_seq_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_seq_rca.sv
// 1-bit full adder cell and the N-bit
// ripple-carry adder chained from it.
module fa_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

module rca_n #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;
  assign cout = c[N];

  for (genvar i = 0; i < N; i++) begin : g_fa
    fa_1 u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .sum  (sum[i]),
      .cout (c[i+1])
    );
  end

endmodule

// File: rtl/mul_seq.sv
// Shift-add multiplier, one multiplier bit per clock.
// Optional MUL_SEQ_SIGNED_EN adds sgn for two's complement.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef MUL_SEQ_SIGNED_EN
  input  logic               sgn,
`endif
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_e state_q;
  state_e state_d;

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum_lo;
  logic               sum_co;
  logic [2*WIDTH-1:0] nxt;
  logic [2*WIDTH-1:0] res;
  logic [WIDTH-1:0]   ma;
  logic [WIDTH-1:0]   mb;
  logic               accept;
  logic               last;

  assign accept = start && (state_q != BUSY);
  assign last   = (cnt == CW'(WIDTH - 1));
  assign busy   = (state_q == BUSY);
  assign done   = (state_q == DONE);

  assign addend = acc_lo[0] ? mcand : '0;

  rca_n #(
    .N (WIDTH)
  ) u_add (
    .a    (acc_hi),
    .b    (addend),
    .cin  (1'b0),
    .sum  (sum_lo),
    .cout (sum_co)
  );

  // carry-out shifts in as the new MSB
  assign nxt = {sum_co, sum_lo, acc_lo[WIDTH-1:1]};

`ifdef MUL_SEQ_SIGNED_EN
  logic neg;
  logic a_neg;
  logic b_neg;

  assign a_neg = sgn & a[WIDTH-1];
  assign b_neg = sgn & b[WIDTH-1];
  assign ma    = a_neg ? ('0 - a) : a;
  assign mb    = b_neg ? ('0 - b) : b;
  assign res   = neg ? ('0 - nxt) : nxt;

  // sign of the result, latched with the operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg <= 1'b0;
    end else if (accept) begin
      neg <= a_neg ^ b_neg;
    end
  end
`else
  assign ma  = a;
  assign mb  = b;
  assign res = nxt;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = BUSY;
      end
      BUSY: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        state_d = start ? BUSY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // operand capture, iteration and result latch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      cnt     <= '0;
      product <= '0;
    end else if (accept) begin
      mcand  <= ma;
      acc_lo <= mb;
      acc_hi <= '0;
      cnt    <= '0;
    end else if (state_q == BUSY) begin
      {acc_hi, acc_lo} <= nxt;
      cnt              <= cnt + CW'(1);
      if (last) product <= res;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq (WIDTH = 8).
// Reference: plain integer multiply of captured operands.
module tb_mul_seq;

  localparam int W = 8;

  logic           clk;
  logic           rst;
  logic           start;
  logic           sgn;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int chk_cnt;
  int pass_cnt;

  mul_seq #(
    .WIDTH (W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef MUL_SEQ_SIGNED_EN
    .sgn     (sgn),
`endif
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] umul(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    int unsigned p;
    p = int'(x) * int'(y);
    return p[2*W-1:0];
  endfunction

  function automatic logic [2*W-1:0] smul(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    int p;
    p = int'($signed(x)) * int'($signed(y));
    return p[2*W-1:0];
  endfunction

  // drive a start for one edge; returns #1 after the accepting edge
  task automatic issue(
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    start = 1'b1;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // count edges from the accepting edge until done is seen
  task automatic wait_done(output int n, output int busy_bad);
    n = 0;
    busy_bad = 0;
    while (done !== 1'b1 && n < 4 * W) begin
      if (busy !== 1'b1) busy_bad++;
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_cnt++;
    if ({busy, done, product} !== {2'b00, 16'h0000})
      $display("FAIL reset: busy=%b done=%b product=%h want 0 0 0000",
               busy, done, product);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int n, bb;
    issue(8'd13, 8'd11);
    wait_done(n, bb);
    chk_cnt++;
    if (n !== W)
      $display("FAIL basic_latency: got %0d want %0d", n, W);
    else pass_cnt++;
    chk_cnt++;
    if (bb !== 0 || busy !== 1'b0)
      $display("FAIL basic_busy: bad=%0d busy=%b want 0 0", bb, busy);
    else pass_cnt++;
    chk_cnt++;
    if (product !== 16'h008F)
      $display("FAIL basic_product: got %h want 008f", product);
    else pass_cnt++;
    @(posedge clk);
    #1;
    chk_cnt++;
    if (done !== 1'b0 || busy !== 1'b0 || product !== 16'h008F)
      $display("FAIL basic_hold: done=%b busy=%b product=%h want 0 0 008f",
               done, busy, product);
    else pass_cnt++;
  endtask

  task automatic test_carry;
    int n, bb;
    issue(8'hFF, 8'hFF);
    wait_done(n, bb);
    chk_cnt++;
    if (product !== 16'hFE01 || n !== W)
      $display("FAIL carry: product=%h n=%0d want fe01 %0d", product, n, W);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back;
    int n, bb;
    issue(8'h00, 8'hA5);
    wait_done(n, bb);
    chk_cnt++;
    if (product !== 16'h0000 || n !== W)
      $display("FAIL b2b_first: product=%h n=%0d want 0000 %0d", product, n, W);
    else pass_cnt++;
    issue(8'hA5, 8'h00);
    chk_cnt++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL b2b_nobubble: busy=%b done=%b want 1 0", busy, done);
    else pass_cnt++;
    wait_done(n, bb);
    chk_cnt++;
    if (product !== 16'h0000 || n !== W)
      $display("FAIL b2b_second: product=%h n=%0d want 0000 %0d", product, n, W);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_ignore_busy;
    int n, bb, extra;
    logic [W-1:0] x, y;
    x = 8'($urandom_range(1, 255));
    y = 8'($urandom_range(1, 255));
    issue(x, y);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    a     = ~x;
    b     = ~y;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(n, bb);
    n = n + 3;
    chk_cnt++;
    if (n !== W || product !== umul(x, y))
      $display("FAIL ignore: product=%h n=%0d want %h %0d",
               product, n, umul(x, y), W);
    else pass_cnt++;
    extra = 0;
    repeat (2 * W) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    chk_cnt++;
    if (extra !== 0)
      $display("FAIL ignore_single: extra active cycles=%0d want 0", extra);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int n, bb, seen;
    issue(8'd200, 8'd77);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk_cnt++;
    if ({busy, done, product} !== {2'b00, 16'h0000})
      $display("FAIL rst_mid: busy=%b done=%b product=%h want 0 0 0000",
               busy, done, product);
    else pass_cnt++;
    seen = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    rst = 1'b0;
    repeat (W) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk_cnt++;
    if (seen !== 0)
      $display("FAIL rst_nodone: active cycles=%0d want 0", seen);
    else pass_cnt++;
    issue(8'd7, 8'd9);
    wait_done(n, bb);
    chk_cnt++;
    if (product !== 16'd63 || n !== W)
      $display("FAIL rst_after: product=%h n=%0d want 003f %0d", product, n, W);
    else pass_cnt++;
    @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    int n, bb, bad;
    logic [W-1:0] x, y;
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      if (i == 0) x = 8'h80;
      if (i == 1) y = 8'h01;
      issue(x, y);
      wait_done(n, bb);
      chk_cnt++;
      if (product !== umul(x, y) || n !== W || bb !== 0) begin
        $display("FAIL random[%0d]: %h*%h got %h n=%0d want %h %0d",
                 i, x, y, product, n, umul(x, y), W);
        bad++;
      end else pass_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

`ifdef MUL_SEQ_SIGNED_EN
  task automatic test_signed;
    int n, bb;
    logic [W-1:0] x, y;
    sgn = 1'b1;
    issue(8'hFD, 8'd5);
    wait_done(n, bb);
    chk_cnt++;
    if (product !== 16'hFFF1 || n !== W)
      $display("FAIL signed_neg: product=%h n=%0d want fff1 %0d", product, n, W);
    else pass_cnt++;
    sgn = 1'b0;
    issue(8'hFD, 8'd5);
    wait_done(n, bb);
    chk_cnt++;
    if (product !== 16'h04F1 || n !== W)
      $display("FAIL signed_off: product=%h n=%0d want 04f1 %0d", product, n, W);
    else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      if (i == 0) begin x = 8'h80; y = 8'h80; end
      sgn = 1'b1;
      issue(x, y);
      wait_done(n, bb);
      chk_cnt++;
      if (product !== smul(x, y) || n !== W)
        $display("FAIL signed_rand[%0d]: %h*%h got %h want %h",
                 i, x, y, product, smul(x, y));
      else pass_cnt++;
    end
    sgn = 1'b0;
    @(posedge clk);
    #1;
  endtask
`endif

  initial begin
    chk_cnt  = 0;
    pass_cnt = 0;
    test_reset;
    test_basic;
    test_carry;
    test_back_to_back;
    test_ignore_busy;
    test_reset_mid;
    test_random;
`ifdef MUL_SEQ_SIGNED_EN
    test_signed;
`endif
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
